// File: rtl/sha256_job_scheduler.sv
// Job scheduler for a bank of SHA256 mining nodes: slices the nonce space, dispatches, collects, reports.
// Optional watchdog enabled by defining SHA_SCHED_TIMEOUT_EN.
module sha256_job_scheduler #(
  parameter int num_nodes_p   = 4,
  parameter int timeout_cyc_p = 2**20
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       job_v_i,
  input  logic [95:0]                job_msg_i,
  input  logic [31:0]                job_target_i,
  output logic                       job_ready_o,
  output logic [num_nodes_p-1:0]     node_v_o,
  input  logic [num_nodes_p-1:0]     node_ready_i,
  output logic [95:0]                node_msg_o,
  output logic [31:0]                node_target_o,
  output logic [31:0]                node_base_o,
  output logic                       node_abort_o,
  input  logic [num_nodes_p-1:0]     node_done_v_i,
  input  logic [num_nodes_p-1:0]     node_found_i,
  input  logic [32*num_nodes_p-1:0]  node_nonce_i,
  output logic [num_nodes_p-1:0]     node_yumi_o,
  output logic                       result_v_o,
  output logic                       result_found_o,
  output logic [31:0]                result_nonce_o,
  input  logic                       result_yumi_i,
  output logic [2:0]                 state_o
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // valid and its payload stay stable until that cycle. node_yumi_o accepts same-cycle.

  localparam int LG_N    = $clog2(num_nodes_p);
  localparam int IDX_W   = (LG_N > 0) ? LG_N : 1;
  localparam int BASE_SH = 32 - LG_N;

  if (num_nodes_p < 1 || num_nodes_p > 16 || (num_nodes_p & (num_nodes_p - 1)) != 0
      || timeout_cyc_p < 1) begin : g_bad_params
    $error("sha256_job_scheduler: illegal parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DISPATCH, S_RUN, S_ABORT, S_REPORT
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [num_nodes_p-1:0] done_mask_q, done_mask_d;
  logic                   found_q, found_d;
  logic [31:0]            nonce_q, nonce_d;
  logic [95:0]            msg_q, msg_d;
  logic [31:0]            target_q, target_d;

  logic [num_nodes_p-1:0] hit_vec;
  logic                   hit_any;
  logic [31:0]            hit_nonce;
  logic                   accept;
  logic                   timeout;

  // Walk downward so the lowest-indexed hitting node wins.
  always_comb begin
    hit_vec   = node_done_v_i & node_found_i;
    hit_any   = |hit_vec;
    hit_nonce = '0;
    for (int k = num_nodes_p - 1; k >= 0; k--) begin
      if (hit_vec[k]) hit_nonce = node_nonce_i[32*k +: 32];
    end
  end

  assign accept = (state_q == S_IDLE) && job_v_i && reset_i;

`ifdef SHA_SCHED_TIMEOUT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (accept) cyc_d = '0;
    else if (state_q == S_DISPATCH || state_q == S_RUN) cyc_d = cyc_q + 32'd1;
  end

  assign timeout = (state_q == S_DISPATCH || state_q == S_RUN)
                   && (cyc_q == 32'(timeout_cyc_p - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_i) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    done_mask_d  = done_mask_q;
    found_d      = found_q;
    nonce_d      = nonce_q;
    msg_d        = msg_q;
    target_d     = target_q;
    job_ready_o  = 1'b0;
    node_v_o     = '0;
    node_base_o  = '0;
    node_abort_o = 1'b0;
    node_yumi_o  = '0;
    result_v_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        job_ready_o = reset_i;
        if (accept) begin
          msg_d       = job_msg_i;
          target_d    = job_target_i;
          idx_d       = '0;
          done_mask_d = '0;
          found_d     = 1'b0;
          nonce_d     = '1;
          state_d     = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        node_v_o[idx_q] = 1'b1;
        node_base_o     = 32'(idx_q) << BASE_SH;
        node_yumi_o     = node_done_v_i;
        done_mask_d     = done_mask_q | node_done_v_i;
        if (hit_any) begin
          found_d = 1'b1;
          nonce_d = hit_nonce;
          state_d = S_ABORT;
        end else if (timeout) begin
          state_d = S_ABORT;
        end else if (node_ready_i[idx_q]) begin
          if (idx_q == IDX_W'(num_nodes_p - 1)) state_d = S_RUN;
          else                                  idx_d   = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        node_yumi_o = node_done_v_i;
        done_mask_d = done_mask_q | node_done_v_i;
        if (hit_any) begin
          found_d = 1'b1;
          nonce_d = hit_nonce;
          state_d = S_ABORT;
        end else if (&done_mask_d) begin
          state_d = S_REPORT;
        end else if (timeout) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        node_abort_o = 1'b1;
        node_yumi_o  = node_done_v_i;
        state_d      = S_REPORT;
      end
      S_REPORT: begin
        result_v_o  = 1'b1;
        node_yumi_o = node_done_v_i;
        if (result_yumi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      done_mask_q <= '0;
      found_q     <= 1'b0;
      nonce_q     <= '1;
      msg_q       <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_mask_q <= done_mask_d;
      found_q     <= found_d;
      nonce_q     <= nonce_d;
      msg_q       <= msg_d;
      target_q    <= target_d;
    end
  end

  assign node_msg_o     = msg_q;
  assign node_target_o  = target_q;
  assign result_found_o = found_q;
  assign result_nonce_o = nonce_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Self-checking bench for sha256_job_scheduler (4 nodes, default build without watchdog).
module tb_sha256_job_scheduler;

  localparam int NN = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          job_v_i;
  logic [95:0]   job_msg_i;
  logic [31:0]   job_target_i;
  logic          job_ready_o;
  logic [NN-1:0] node_v_o;
  logic [NN-1:0] node_ready_i;
  logic [95:0]   node_msg_o;
  logic [31:0]   node_target_o;
  logic [31:0]   node_base_o;
  logic          node_abort_o;
  logic [NN-1:0] node_done_v_i;
  logic [NN-1:0] node_found_i;
  logic [32*NN-1:0] node_nonce_i;
  logic [NN-1:0] node_yumi_o;
  logic          result_v_o;
  logic          result_found_o;
  logic [31:0]   result_nonce_o;
  logic          result_yumi_i;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [95:0]   exp_msg;
  logic [31:0]   exp_target;
  int            stall[NN];
  logic [NN-1:0] plan_done[$];
  logic [NN-1:0] plan_found[$];
  logic [31:0]   plan_nonce[NN];

  sha256_job_scheduler #(.num_nodes_p(NN)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .job_v_i(job_v_i), .job_msg_i(job_msg_i), .job_target_i(job_target_i),
    .job_ready_o(job_ready_o),
    .node_v_o(node_v_o), .node_ready_i(node_ready_i),
    .node_msg_o(node_msg_o), .node_target_o(node_target_o), .node_base_o(node_base_o),
    .node_abort_o(node_abort_o),
    .node_done_v_i(node_done_v_i), .node_found_i(node_found_i), .node_nonce_i(node_nonce_i),
    .node_yumi_o(node_yumi_o),
    .result_v_o(result_v_o), .result_found_o(result_found_o), .result_nonce_o(result_nonce_o),
    .result_yumi_i(result_yumi_i),
    .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_nodes();
    node_done_v_i = '0;
    node_found_i  = '0;
    node_ready_i  = '0;
  endtask

  task automatic load_nonces();
    for (int k = 0; k < NN; k++) node_nonce_i[32*k +: 32] = plan_nonce[k];
  endtask

  task automatic job_accept(input logic [95:0] msg, input logic [31:0] tgt);
    exp_msg      = msg;
    exp_target   = tgt;
    job_v_i      = 1'b1;
    job_msg_i    = msg;
    job_target_i = tgt;
    #2;
    chk("accept_ready", job_ready_o, 1'b1);
    chk("accept_no_v", node_v_o, '0);
    tick();
    job_v_i      = 1'b0;
    job_msg_i    = {$urandom, $urandom, $urandom};
    job_target_i = $urandom;
  endtask

  // Slice k of NN equal slices of the 2^32 nonce space starts at k * 2^32/NN.
  task automatic dispatch_all();
    for (int i = 0; i < NN; i++) begin
      for (int s = 0; s <= stall[i]; s++) begin
        logic [NN-1:0] sel;
        logic [31:0]   exp_base;
        sel          = NN'(1 << i);
        exp_base     = 32'(64'(i) * (64'h1_0000_0000 / NN));
        node_ready_i = (NN'($urandom) & ~sel) | ((s == stall[i]) ? sel : '0);
        #2;
        chk("disp_v", node_v_o, sel);
        chk("disp_base", node_base_o, exp_base);
        chk("disp_msg", node_msg_o, exp_msg);
        chk("disp_target", node_target_o, exp_target);
        chk("disp_no_abort", node_abort_o, 1'b0);
        tick();
      end
    end
    node_ready_i = '0;
  endtask

  // Replays the result plan; the first cycle with any qualified hit decides the winner.
  task automatic run_plan(output logic exp_hit, output logic [31:0] exp_nonce);
    logic [NN-1:0] seen;
    exp_hit   = 1'b0;
    exp_nonce = 32'hFFFF_FFFF;
    seen      = '0;
    load_nonces();
    for (int c = 0; c < plan_done.size(); c++) begin
      logic [NN-1:0] hits;
      node_done_v_i = plan_done[c];
      node_found_i  = plan_found[c] | (NN'($urandom) & ~plan_done[c]);
      hits          = plan_done[c] & plan_found[c];
      #2;
      chk("run_yumi", node_yumi_o, plan_done[c]);
      chk("run_no_abort", node_abort_o, 1'b0);
      chk("run_no_result", result_v_o, 1'b0);
      tick();
      if (hits != '0) begin
        exp_hit = 1'b1;
        for (int k = NN - 1; k >= 0; k--) if (hits[k]) exp_nonce = plan_nonce[k];
        break;
      end
      seen = seen | plan_done[c];
      if (seen == '1) break;
    end
    clear_nodes();
  endtask

  // Entered at the sample point of the first REPORT cycle.
  task automatic report_phase(input logic exp_found, input logic [31:0] exp_nonce);
    int h;
    chk("rep_valid", result_v_o, 1'b1);
    chk("rep_found", result_found_o, exp_found);
    chk("rep_nonce", result_nonce_o, exp_nonce);
    chk("rep_abort_once", node_abort_o, 1'b0);
    h = $urandom_range(0, 3);
    repeat (h) begin
      tick();
      node_done_v_i = NN'($urandom);
      node_found_i  = NN'($urandom);
      #2;
      chk("hold_valid", result_v_o, 1'b1);
      chk("hold_found", result_found_o, exp_found);
      chk("hold_nonce", result_nonce_o, exp_nonce);
      chk("hold_yumi", node_yumi_o, node_done_v_i);
    end
    tick();
    clear_nodes();
    result_yumi_i = 1'b1;
    #2;
    chk("yumi_valid", result_v_o, 1'b1);
    tick();
    result_yumi_i = 1'b0;
    node_done_v_i = NN'($urandom_range(1, 15));
    #2;
    chk("idle_ready", job_ready_o, 1'b1);
    chk("idle_no_result", result_v_o, 1'b0);
    chk("idle_no_yumi", node_yumi_o, '0);
    tick();
    clear_nodes();
  endtask

  task automatic finish_job(input logic exp_hit, input logic [31:0] exp_nonce);
    if (exp_hit) begin
      node_done_v_i = NN'($urandom);
      node_found_i  = NN'($urandom);
      #2;
      chk("abort_pulse", node_abort_o, 1'b1);
      chk("abort_no_result", result_v_o, 1'b0);
      chk("abort_no_v", node_v_o, '0);
      chk("abort_yumi", node_yumi_o, node_done_v_i);
      tick();
      clear_nodes();
      #2;
      report_phase(1'b1, exp_nonce);
    end else begin
      logic saw_abort = 1'b0;
      logic saw_rep   = 1'b0;
      for (int w = 0; w < 4; w++) begin
        #2;
        if (node_abort_o) saw_abort = 1'b1;
        if (result_v_o) begin
          saw_rep = 1'b1;
          break;
        end
        tick();
      end
      chk("nohit_no_abort", saw_abort, 1'b0);
      chk("nohit_report_seen", saw_rep, 1'b1);
      if (saw_rep) report_phase(1'b0, 32'hFFFF_FFFF);
    end
  endtask

  task automatic full_job();
    logic        hit;
    logic [31:0] nonce;
    job_accept({$urandom, $urandom, $urandom}, $urandom);
    dispatch_all();
    run_plan(hit, nonce);
    finish_job(hit, nonce);
  endtask

  task automatic set_stalls(input int s0, input int s1, input int s2, input int s3);
    stall[0] = s0; stall[1] = s1; stall[2] = s2; stall[3] = s3;
  endtask

  task automatic random_nonces();
    for (int k = 0; k < NN; k++) plan_nonce[k] = {2'(k), 30'($urandom)};
  endtask

  initial begin
    reset_i       = 1'b0;
    job_v_i       = 1'b0;
    job_msg_i     = '0;
    job_target_i  = '0;
    result_yumi_i = 1'b0;
    node_nonce_i  = '0;
    clear_nodes();

    // Reset state
    tick();
    tick();
    #2;
    chk("rst_ready", job_ready_o, 1'b0);
    chk("rst_v", node_v_o, '0);
    chk("rst_abort", node_abort_o, 1'b0);
    chk("rst_result_v", result_v_o, 1'b0);
    chk("rst_found", result_found_o, 1'b0);
    chk("rst_nonce", result_nonce_o, 32'hFFFF_FFFF);
    chk("rst_base", node_base_o, 32'h0);
    chk("rst_msg", node_msg_o, 96'h0);
    tick();
    reset_i = 1'b1;
    #2;
    chk("post_rst_ready", job_ready_o, 1'b1);
    tick();

    // T1 + T2: back-to-back dispatch, node 2 hits
    set_stalls(0, 0, 0, 0);
    random_nonces();
    plan_nonce[2] = 32'h8000_1234;
    plan_done.delete(); plan_found.delete();
    plan_done.push_back(4'b0000); plan_found.push_back(4'b0000);
    plan_done.push_back(4'b0100); plan_found.push_back(4'b0100);
    begin
      logic hit; logic [31:0] nonce;
      job_accept(96'h0123_4567_89AB_CDEF_0011_2233, 32'h0000_FFFF);
      dispatch_all();
      run_plan(hit, nonce);
      finish_job(hit, nonce);
    end

    // T3: nodes 1 and 3 hit together
    random_nonces();
    plan_nonce[1] = 32'h4000_0007;
    plan_nonce[3] = 32'hC000_0001;
    plan_done.delete(); plan_found.delete();
    plan_done.push_back(4'b1010); plan_found.push_back(4'b1010);
    full_job();

    // T4: all done, no hit
    random_nonces();
    plan_done.delete(); plan_found.delete();
    plan_done.push_back(4'b0001); plan_found.push_back(4'b0000);
    plan_done.push_back(4'b0110); plan_found.push_back(4'b0000);
    plan_done.push_back(4'b0000); plan_found.push_back(4'b0000);
    plan_done.push_back(4'b1000); plan_found.push_back(4'b0000);
    full_job();

    // Hit during dispatch stops further dispatch
    job_accept({$urandom, $urandom, $urandom}, $urandom);
    node_ready_i = 4'b0001;
    #2;
    chk("dh_v0", node_v_o, 4'b0001);
    tick();
    node_ready_i  = 4'b0000;
    node_done_v_i = 4'b0001;
    node_found_i  = 4'b0001;
    node_nonce_i  = {96'h0, 32'h0000_00AB};
    #2;
    chk("dh_v1", node_v_o, 4'b0010);
    chk("dh_yumi", node_yumi_o, 4'b0001);
    tick();
    clear_nodes();
    finish_job(1'b1, 32'h0000_00AB);

    // T5: node 1 stalls 5 cycles, then reset mid-RUN
    set_stalls(0, 5, 0, 0);
    job_accept({$urandom, $urandom, $urandom}, $urandom);
    dispatch_all();
    node_done_v_i = 4'b0001;
    #2;
    chk("t5_yumi", node_yumi_o, 4'b0001);
    tick();
    clear_nodes();
    reset_i = 1'b0;
    #2;
    chk("t5_rst_no_abort", node_abort_o, 1'b0);
    tick();
    #2;
    chk("t5_rst_no_abort2", node_abort_o, 1'b0);
    chk("t5_rst_no_result", result_v_o, 1'b0);
    chk("t5_rst_v", node_v_o, '0);
    chk("t5_rst_ready", job_ready_o, 1'b0);
    chk("t5_rst_nonce", result_nonce_o, 32'hFFFF_FFFF);
    chk("t5_rst_found", result_found_o, 1'b0);
    tick();
    reset_i = 1'b1;
    #2;
    chk("t5_ready_after", job_ready_o, 1'b1);
    tick();

    // Randomized jobs: random stalls and random result arrival
    for (int j = 0; j < 20; j++) begin
      logic [NN-1:0] rem;
      int            cyc;
      set_stalls($urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      random_nonces();
      plan_done.delete(); plan_found.delete();
      rem = '1;
      cyc = 0;
      while (rem != '0) begin
        logic [NN-1:0] d;
        d = (cyc > 12) ? rem : (NN'($urandom) & rem);
        plan_done.push_back(d);
        plan_found.push_back(($urandom_range(0, 5) == 0) ? (NN'($urandom) & d) : '0);
        rem = rem & ~d;
        cyc++;
      end
      full_job();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
